// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    localparam int RV32_ADDR_WIDTH = 32;

    localparam logic JUMP_ENABLE   = 1'b1;
    localparam logic JUMP_DISABLE  = 1'b0;
    localparam logic HOLD_ENABLE   = 1'b1;
    localparam logic HOLD_DISABLE  = 1'b0;
    localparam logic FLUSH_ENABLE  = 1'b1;
    localparam logic FLUSH_DISABLE = 1'b0;
    localparam logic RST_ENABLE    = 1'b0;

    typedef enum logic {
        PIPE_CTRL_ST_RUN        = 1'b0,
        PIPE_CTRL_ST_STALL_PEND = 1'b1
    } pipe_ctrl_st_t;

    typedef struct packed {
        logic [RV32_ADDR_WIDTH-1:0] addr;
        logic                       is_trap;
    } pend_t;

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Stall-cycle and redirect-cycle counters for the pipeline control unit.
// Latency: counts appear one clk after the counted cycle; wrap at 2^32.
// Backpressure: none, counts every qualifying cycle.
module pipe_ctrl_perf_cnt
    import pipe_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hold,
    input  logic                       jump_en,
    output logic [RV32_ADDR_WIDTH-1:0] stall_cnt,
    output logic [RV32_ADDR_WIDTH-1:0] redirect_cnt
);

    logic [RV32_ADDR_WIDTH-1:0] stall_cnt_q;
    logic [RV32_ADDR_WIDTH-1:0] redirect_cnt_q;

    // Free-running wrapping counters qualified by hold / jump enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (hold)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (jump_en)
                redirect_cnt_q <= redirect_cnt_q + 1'b1;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Redirect arbitration (trap over EX) and hold/flush merge; replays redirects latched during a stall. Optional counters: PIPE_CTRL_PERF_CNT_EN.
// Latency: 0 cycles, request to jump_en_o is combinational; a stalled redirect is emitted in the first cycle hold is low.
// Backpressure: hold_o (ex/bus stall) defers redirects into a one-entry pending register; a trap overwrites it, EX only overwrites a pending EX.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ex_jump_en_i,
    input  logic [RV32_ADDR_WIDTH-1:0] ex_jump_addr_i,
    input  logic                       trap_jump_en_i,
    input  logic [RV32_ADDR_WIDTH-1:0] trap_jump_addr_i,
    input  logic                       ex_hold_req_i,
    input  logic                       bus_hold_req_i,
    output logic                       jump_en_o,
    output logic [RV32_ADDR_WIDTH-1:0] jump_addr_o,
    output logic                       hold_o,
    output logic                       flush_o
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [RV32_ADDR_WIDTH-1:0] stall_cnt_o,
    output logic [RV32_ADDR_WIDTH-1:0] redirect_cnt_o
`endif
);

    pipe_ctrl_st_t state_q, state_d;
    pend_t         pend_q, pend_d;

    logic                       hold;
    logic                       req_vld;
    logic [RV32_ADDR_WIDTH-1:0] win_addr;

    assign hold     = ex_hold_req_i | bus_hold_req_i;
    assign req_vld  = ex_jump_en_i | trap_jump_en_i;
    // Trap wins a same-cycle collision; the EX request is simply dropped.
    assign win_addr = trap_jump_en_i ? trap_jump_addr_i : ex_jump_addr_i;

    // State and pending-redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            state_q <= PIPE_CTRL_ST_RUN;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state, pending update and redirect outputs.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        jump_en_o   = JUMP_DISABLE;
        jump_addr_o = '0;
        case (state_q)
            PIPE_CTRL_ST_RUN: begin
                if (req_vld) begin
                    if (!hold) begin
                        jump_en_o   = JUMP_ENABLE;
                        jump_addr_o = win_addr;
                    end else begin
                        pend_d.addr    = win_addr;
                        pend_d.is_trap = trap_jump_en_i;
                        state_d        = PIPE_CTRL_ST_STALL_PEND;
                    end
                end
            end
            PIPE_CTRL_ST_STALL_PEND: begin
                if (hold) begin
                    // A pending trap must never be displaced by a younger EX redirect.
                    if (trap_jump_en_i) begin
                        pend_d.addr    = trap_jump_addr_i;
                        pend_d.is_trap = 1'b1;
                    end else if (ex_jump_en_i && !pend_q.is_trap) begin
                        pend_d.addr = ex_jump_addr_i;
                    end
                end else begin
                    jump_en_o   = JUMP_ENABLE;
                    jump_addr_o = trap_jump_en_i ? trap_jump_addr_i : pend_q.addr;
                    pend_d      = '0;
                    state_d     = PIPE_CTRL_ST_RUN;
                end
            end
            default: begin
                state_d = PIPE_CTRL_ST_RUN;
                pend_d  = '0;
            end
        endcase
    end

    assign hold_o  = hold ? HOLD_ENABLE : HOLD_DISABLE;
    assign flush_o = jump_en_o ? FLUSH_ENABLE : FLUSH_DISABLE;

`ifdef PIPE_CTRL_PERF_CNT_EN
    pipe_ctrl_perf_cnt u_perf_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold         (hold_o),
        .jump_en      (jump_en_o),
        .stall_cnt    (stall_cnt_o),
        .redirect_cnt (redirect_cnt_o)
    );
`endif

endmodule
